uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated transmit FIFO and runtime-selectable frame format. It runs on the system clock and is paced by a one-clock baud-tick enable at OVERSAMPLE times the bit rate. It sits behind the CPU's UART peripheral registers and drives the UARTTx pin. Unlike the single-byte transmitter, it supports queued bytes, 5–8 data bits, parity, one or two stop bits, and back-to-back frames with no idle gap.

---
 rtl/uart_tx_fifo.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated transmit FIFO and a
// per-frame format (5-8 data bits, none/even/odd parity, 1 or 2 stop bits).
// Bits are paced by baud_tick, a one-clock enable at OVERSAMPLE x bit rate.
// Queued bytes are sent back-to-back with no idle gap between frames.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        asynchronous, active-low reset
//   baud_tick    one-clk enable at OVERSAMPLE x baud
//   wr_en        push wr_data into the FIFO this cycle
//   wr_data      byte to send, LSB first
//   data_len     00=5, 01=6, 10=7, 11=8 data bits
//   parity_mode  00/11=none, 01=even, 10=odd
//   stop2        1 = two stop bits
//   clr_ovf      clears the sticky overflow flag
//   UARTTx       serial line, idle high, registered
//   tx_busy      frame in progress
//   tx_done      one-clk pulse at end of the last stop bit
//   fifo_empty   FIFO holds no entries
//   fifo_full    FIFO holds FIFO_DEPTH entries
//   fifo_count   entries stored
//   ovf          sticky: a write was dropped because the FIFO was full
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          baud_tick,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic [1:0]                    data_len,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          clr_ovf,
  output logic                          UARTTx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] TICK_MAX = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] TICK_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   tick_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [1:0]      len_l;
  logic            par_en_l;
  logic            par_bit_l;
  logic            stop2_l;

  logic            push;
  logic            pop;
  logic            tick_end;
  logic            frame_end;
  logic [7:0]      head;
  logic [7:0]      masked;
  logic [2:0]      last_idx;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH_C);
  assign tx_busy    = (state != IDLE);
  assign head       = mem[rptr];

  always_comb begin
    push      = wr_en && !fifo_full;
    tick_end  = baud_tick && (tick_cnt == TICK_MAX);
    // bit_idx counts stop bits while in STOP: 0 = first, 1 = second
    frame_end = (state == STOP) && tick_end && (!stop2_l || (bit_idx != 3'd0));
    pop       = !fifo_empty && ((state == IDLE) || frame_end);
    masked    = head & (8'hFF >> (2'd3 - data_len));
    last_idx  = 3'd4 + {1'b0, len_l};
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      if (wr_en && fifo_full) ovf <= 1'b1;
      else if (clr_ovf)       ovf <= 1'b0;
    end
  end

  // ---------------- transmit FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      UARTTx    <= 1'b1;
      tx_done   <= 1'b0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      len_l     <= '0;
      par_en_l  <= 1'b0;
      par_bit_l <= 1'b0;
      stop2_l   <= 1'b0;
    end else begin
      tx_done <= frame_end;

      if (tick_end)
        tick_cnt <= '0;
      else if (baud_tick && state != IDLE)
        tick_cnt <= tick_cnt + TICK_ONE;

      case (state)
        IDLE: UARTTx <= 1'b1;
        START: begin
          if (tick_end) begin
            state   <= DATA;
            bit_idx <= '0;
            UARTTx  <= shift[0];
          end
        end
        DATA: begin
          if (tick_end) begin
            if (bit_idx == last_idx) begin
              bit_idx <= '0;
              if (par_en_l) begin
                state  <= PARITY;
                UARTTx <= par_bit_l;
              end else begin
                state  <= STOP;
                UARTTx <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              UARTTx  <= shift[1];
            end
          end
        end
        PARITY: begin
          if (tick_end) begin
            state   <= STOP;
            bit_idx <= '0;
            UARTTx  <= 1'b1;
          end
        end
        STOP: begin
          if (frame_end) begin
            state  <= IDLE;
            UARTTx <= 1'b1;
          end else if (tick_end) begin
            bit_idx <= 3'd1;
          end
        end
        default: begin
          state  <= IDLE;
          UARTTx <= 1'b1;
        end
      endcase

      // A pop (from IDLE or at the end of the final stop bit) overrides the
      // per-state assignments above so the next start bit begins on this edge.
      if (pop) begin
        state     <= START;
        UARTTx    <= 1'b0;
        tick_cnt  <= '0;
        bit_idx   <= '0;
        shift     <= head;
        len_l     <= data_len;
        par_en_l  <= ^parity_mode;
        par_bit_l <= (^masked) ^ (parity_mode == 2'b10);
        stop2_l   <= stop2;
      end
    end
  end

endmodule
